// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU memory stage: lane count, data width, sequencer
// states and the per-lane vector type.
package gpu_mem_pkg;

    localparam int N     = 18;
    localparam int LANES = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD       = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_t;

    typedef logic [LANES-1:0][N-1:0] lane_vec_t;

    // The lane counter never reaches 3; that code falls back to lane 0.
    function automatic logic [N-1:0] lane_sel(input lane_vec_t v, input logic [1:0] lane);
        logic [N-1:0] r;
        case (lane)
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = v[0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_sequencer.sv
// Memory-access stage: serialises a 3-lane vector load/store onto a single-port
// data memory one lane per cycle, stalling upstream, then emits one result vector.
//
// state    | meaning
// IDLE     | accepting; passthrough results issued directly from here
// RD       | mem_re for lane 0..2; read data from the previous lane is stored
// RD_DRAIN | last lane's read data arrives; result vector is registered
// WR       | mem_we for lane 0..2; result registered after lane 2
module mem_lane_sequencer
    import gpu_mem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  lane_vec_t       addr_vec,
    input  lane_vec_t       wdata_vec,
    input  logic [3:0]      wa3,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    input  logic            mem_write,
    output logic            stall,
    output logic [N-1:0]    mem_addr,
    output logic [N-1:0]    mem_wdata,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [N-1:0]    mem_rdata,
    output logic            out_valid,
    output lane_vec_t       out_data,
    output logic [3:0]      out_wa3,
    output logic            out_reg_write,
    output logic            out_mem_to_reg
);

    state_t     state_q, state_d;
    logic [1:0] lane_q, lane_d;
    lane_vec_t  cap_addr_q, cap_addr_d;
    lane_vec_t  cap_wdata_q, cap_wdata_d;
    logic [3:0] cap_wa3_q, cap_wa3_d;
    logic       cap_rw_q, cap_rw_d;
    logic       cap_m2r_q, cap_m2r_d;
    lane_vec_t  rd_q, rd_d;
    logic       out_valid_q, out_valid_d;
    lane_vec_t  out_data_q, out_data_d;
    logic [3:0] out_wa3_q, out_wa3_d;
    logic       out_rw_q, out_rw_d;
    logic       out_m2r_q, out_m2r_d;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_wa3_d   = cap_wa3_q;
        cap_rw_d    = cap_rw_q;
        cap_m2r_d   = cap_m2r_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_wa3_d   = out_wa3_q;
        out_rw_d    = out_rw_q;
        out_m2r_d   = out_m2r_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_write || mem_to_reg) begin
                        cap_addr_d  = addr_vec;
                        cap_wdata_d = wdata_vec;
                        cap_wa3_d   = wa3;
                        cap_rw_d    = reg_write;
                        cap_m2r_d   = mem_to_reg;
                        lane_d      = 2'd0;
                        state_d     = mem_write ? WR : RD;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = addr_vec;
                        out_wa3_d   = wa3;
                        out_rw_d    = reg_write;
                        out_m2r_d   = mem_to_reg;
                    end
                end
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = lane_sel(cap_addr_q, lane_q);
                mem_wdata = lane_sel(cap_wdata_q, lane_q);
                if (lane_q == 2'd2) begin
                    lane_d      = 2'd0;
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_data_d  = cap_addr_q;
                    out_wa3_d   = cap_wa3_q;
                    out_rw_d    = cap_rw_q;
                    out_m2r_d   = cap_m2r_q;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = lane_sel(cap_addr_q, lane_q);
                // Read data lags the strobe by one cycle, so it belongs to lane-1.
                case (lane_q)
                    2'd1:    rd_d[0] = mem_rdata;
                    2'd2:    rd_d[1] = mem_rdata;
                    default: ;
                endcase
                if (lane_q == 2'd2) begin
                    lane_d  = 2'd0;
                    state_d = RD_DRAIN;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            RD_DRAIN: begin
                rd_d[2]     = mem_rdata;
                out_valid_d = 1'b1;
                out_data_d  = {mem_rdata, rd_q[1], rd_q[0]};
                out_wa3_d   = cap_wa3_q;
                out_rw_d    = cap_rw_q;
                out_m2r_d   = cap_m2r_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_wa3_q   <= '0;
            cap_rw_q    <= 1'b0;
            cap_m2r_q   <= 1'b0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_wa3_q   <= '0;
            out_rw_q    <= 1'b0;
            out_m2r_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_wa3_q   <= cap_wa3_d;
            cap_rw_q    <= cap_rw_d;
            cap_m2r_q   <= cap_m2r_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_wa3_q   <= out_wa3_d;
            out_rw_q    <= out_rw_d;
            out_m2r_q   <= out_m2r_d;
        end
    end

    assign stall          = (state_q != IDLE);
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_wa3        = out_wa3_q;
    assign out_reg_write  = out_rw_q;
    assign out_mem_to_reg = out_m2r_q;

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// Directed bench for mem_lane_sequencer: scoreboards for result vectors and
// memory strobes, plus cycle-exact stall/strobe/out_valid checks.
module tb_mem_lane_sequencer;
    import gpu_mem_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    lane_vec_t       addr_vec, wdata_vec;
    logic [3:0]      wa3;
    logic            reg_write, mem_to_reg, mem_write;
    logic            stall;
    logic [N-1:0]    mem_addr, mem_wdata, mem_rdata;
    logic            mem_we, mem_re;
    logic            out_valid;
    lane_vec_t       out_data;
    logic [3:0]      out_wa3;
    logic            out_reg_write, out_mem_to_reg;

    mem_lane_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .addr_vec(addr_vec), .wdata_vec(wdata_vec), .wa3(wa3),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_wa3(out_wa3),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg)
    );

    always #5 clk = ~clk;

    // Memory model: read data is address+1, returned the cycle after mem_re.
    always @(posedge clk) mem_rdata <= mem_re ? N'(mem_addr + 1) : '0;

    typedef struct {
        lane_vec_t  data;
        logic [3:0] wa3;
        logic       rw;
        logic       m2r;
    } res_t;

    typedef struct {
        logic         we;
        logic         re;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
    } mop_t;

    res_t sb[$];
    mop_t mq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic lane_vec_t vec(input logic [N-1:0] l0, input logic [N-1:0] l1,
                                      input logic [N-1:0] l2);
        lane_vec_t v;
        v[0] = l0;
        v[1] = l1;
        v[2] = l2;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        res_t r;
        mop_t m;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                r = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(r.data));
                chk("out_wa3", 64'(out_wa3), 64'(r.wa3));
                chk("out_reg_write", 64'(out_reg_write), 64'(r.rw));
                chk("out_mem_to_reg", 64'(out_mem_to_reg), 64'(r.m2r));
            end
        end
        if (mem_we === 1'b1 || mem_re === 1'b1) begin
            if (mq.size() == 0) begin
                chk("spurious_mem_strobe", 64'({mem_we, mem_re}), 64'd0);
            end else begin
                m = mq.pop_front();
                chk("mem_we", 64'(mem_we), 64'(m.we));
                chk("mem_re", 64'(mem_re), 64'(m.re));
                chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                if (m.we) chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
            end
        end
    endtask

    task automatic drive(input logic iv, input lane_vec_t a, input lane_vec_t w,
                         input logic [3:0] d, input logic rw, input logic m2r,
                         input logic mw);
        in_valid   = iv;
        addr_vec   = a;
        wdata_vec  = w;
        wa3        = d;
        reg_write  = rw;
        mem_to_reg = m2r;
        mem_write  = mw;
    endtask

    task automatic push_res(input lane_vec_t d, input logic [3:0] w, input logic rw,
                            input logic m2r);
        res_t r;
        r.data = d; r.wa3 = w; r.rw = rw; r.m2r = m2r;
        sb.push_back(r);
    endtask

    task automatic push_mop(input logic we, input logic [N-1:0] a, input logic [N-1:0] wd);
        mop_t m;
        m.we = we; m.re = ~we; m.addr = a; m.wdata = wd;
        mq.push_back(m);
    endtask

    initial begin
        lane_vec_t a, w;

        reset = 1'b1;
        drive(1'b0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_mem", 64'({mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'({out_data, out_wa3, out_reg_write, out_mem_to_reg}), 64'd0);
        reset = 1'b0;
        tick();

        // Passthrough x3 back to back
        a = vec(18'd1, 18'd2, 18'd3);
        drive(1'b1, a, '0, 4'd1, 1'b1, 1'b0, 1'b0);
        push_res(a, 4'd1, 1'b1, 1'b0);
        tick();
        chk("pt1_ov", 64'(out_valid), 64'd1);
        chk("pt1_stall", 64'(stall), 64'd0);
        a = vec(18'd4, 18'd5, 18'd6);
        drive(1'b1, a, '0, 4'd2, 1'b1, 1'b0, 1'b0);
        push_res(a, 4'd2, 1'b1, 1'b0);
        tick();
        chk("pt2_ov", 64'(out_valid), 64'd1);
        chk("pt2_stall", 64'(stall), 64'd0);
        a = vec(18'd7, 18'd8, 18'd9);
        drive(1'b1, a, '0, 4'd3, 1'b0, 1'b0, 1'b0);
        push_res(a, 4'd3, 1'b0, 1'b0);
        tick();
        chk("pt3_ov", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("pt_ov_single", 64'(out_valid), 64'd0);
        chk("pt_hold", 64'(out_data), 64'(vec(18'd7, 18'd8, 18'd9)));
        chk("pt_sb_empty", 64'(sb.size()), 64'd0);

        // Load: T accept, mem_re T+1..T+3, out_valid T+5
        a = vec(18'h10, 18'h20, 18'h30);
        drive(1'b1, a, '0, 4'd5, 1'b1, 1'b1, 1'b0);
        push_res(vec(18'h11, 18'h21, 18'h31), 4'd5, 1'b1, 1'b1);
        push_mop(1'b0, 18'h10, '0);
        push_mop(1'b0, 18'h20, '0);
        push_mop(1'b0, 18'h30, '0);
        tick();
        in_valid = 1'b0;
        chk("ld_t1_stall", 64'(stall), 64'd1);
        chk("ld_t1_re", 64'(mem_re), 64'd1);
        tick();
        chk("ld_t2_re", 64'(mem_re), 64'd1);
        tick();
        chk("ld_t3_re", 64'(mem_re), 64'd1);
        tick();
        chk("ld_t4_stall", 64'(stall), 64'd1);
        chk("ld_t4_re", 64'(mem_re), 64'd0);
        chk("ld_t4_ov", 64'(out_valid), 64'd0);
        tick();
        chk("ld_t5_ov", 64'(out_valid), 64'd1);
        chk("ld_t5_stall", 64'(stall), 64'd0);
        tick();
        chk("ld_sb_empty", 64'(sb.size() + mq.size()), 64'd0);

        // Store: mem_we T+1..T+3, out_valid T+4
        a = vec(18'd4, 18'd8, 18'd12);
        w = vec(18'h3FFFF, 18'd0, 18'd7);
        drive(1'b1, a, w, 4'd9, 1'b0, 1'b0, 1'b1);
        push_res(a, 4'd9, 1'b0, 1'b0);
        push_mop(1'b1, 18'd4, 18'h3FFFF);
        push_mop(1'b1, 18'd8, 18'd0);
        push_mop(1'b1, 18'd12, 18'd7);
        tick();
        in_valid = 1'b0;
        chk("st_t1_we", 64'(mem_we), 64'd1);
        tick();
        tick();
        chk("st_t3_stall", 64'(stall), 64'd1);
        tick();
        chk("st_t4_ov", 64'(out_valid), 64'd1);
        chk("st_t4_stall", 64'(stall), 64'd0);
        chk("st_t4_we", 64'(mem_we), 64'd0);
        tick();
        chk("st_sb_empty", 64'(sb.size() + mq.size()), 64'd0);

        // Load followed by a held passthrough: accepted at T+5, out at T+6
        a = vec(18'd100, 18'd200, 18'd300);
        drive(1'b1, a, '0, 4'd6, 1'b1, 1'b1, 1'b0);
        push_res(vec(18'd101, 18'd201, 18'd301), 4'd6, 1'b1, 1'b1);
        push_mop(1'b0, 18'd100, '0);
        push_mop(1'b0, 18'd200, '0);
        push_mop(1'b0, 18'd300, '0);
        tick();
        a = vec(18'h2AAAA, 18'h15555, 18'd42);
        drive(1'b1, a, '0, 4'd12, 1'b1, 1'b0, 1'b0);
        push_res(a, 4'd12, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("lp_t4_ov", 64'(out_valid), 64'd0);
        tick();
        chk("lp_t5_ov", 64'(out_valid), 64'd1);
        chk("lp_t5_wa3", 64'(out_wa3), 64'd6);
        tick();
        chk("lp_t6_ov", 64'(out_valid), 64'd1);
        chk("lp_t6_wa3", 64'(out_wa3), 64'd12);
        in_valid = 1'b0;
        tick();
        chk("lp_t7_ov", 64'(out_valid), 64'd0);
        chk("lp_sb_empty", 64'(sb.size() + mq.size()), 64'd0);

        // mem_write and mem_to_reg both set: store wins, no mem_re at all
        a = vec(18'd21, 18'd22, 18'd23);
        w = vec(18'd31, 18'd32, 18'd33);
        drive(1'b1, a, w, 4'd15, 1'b1, 1'b1, 1'b1);
        push_res(a, 4'd15, 1'b1, 1'b1);
        push_mop(1'b1, 18'd21, 18'd31);
        push_mop(1'b1, 18'd22, 18'd32);
        push_mop(1'b1, 18'd23, 18'd33);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("both_no_re", 64'(mem_re), 64'd0);
            tick();
        end
        chk("both_ov", 64'(out_valid), 64'd1);
        tick();
        chk("both_sb_empty", 64'(sb.size() + mq.size()), 64'd0);

        // Reset during a load at T+2
        a = vec(18'd50, 18'd60, 18'd70);
        drive(1'b1, a, '0, 4'd3, 1'b1, 1'b1, 1'b0);
        push_mop(1'b0, 18'd50, '0);
        push_mop(1'b0, 18'd60, '0);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rmid_stall", 64'(stall), 64'd0);
        chk("rmid_re", 64'(mem_re), 64'd0);
        chk("rmid_ov", 64'(out_valid), 64'd0);
        chk("rmid_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        tick();
        chk("rmid_ov_after", 64'(out_valid), 64'd0);
        a = vec(18'd5, 18'd6, 18'd7);
        drive(1'b1, a, '0, 4'd8, 1'b1, 1'b0, 1'b0);
        push_res(a, 4'd8, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rpt_ov", 64'(out_valid), 64'd1);
        chk("rpt_stall", 64'(stall), 64'd0);
        tick();
        chk("final_sb_empty", 64'(sb.size() + mq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_lane_sequencer.md
# mem_lane_sequencer

Memory-access stage of the filter GPU pipeline, sitting directly downstream of the ALU/EX-MEM buffer and upstream of the MEM-WB buffer. It takes a 3-lane vector instruction (per-lane addresses/ALU results, per-lane store data, control bits) and serialises its memory traffic onto a single-port data memory, one lane per cycle. While a vector access is in flight, it stalls the upstream buffer. It then presents one registered result vector to write-back.

## Interface
- N, 18, data/address width per lane
- LANES, 3, vector lanes (fixed; counters sized for 3)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- in_valid  in  1  upstream buffer holds a valid instruction
- addr_vec  in  [3][N]  ALU result per lane; memory address for loads/stores
- wdata_vec  in  [3][N]  store data per lane
- wa3  in  4  destination register
- reg_write, mem_to_reg, mem_write  in  1 each  control bits
- stall  out  1  upstream buffer must not load while high
- mem_addr  out  N  data-memory address
- mem_wdata  out  N  data-memory write data
- mem_we, mem_re  out  1 each  write / read strobes
- mem_rdata  in  N  read data, valid the cycle after mem_re
- out_valid  out  1  one-cycle result pulse to the MEM-WB buffer
- out_data  out  [3][N]  per-lane result (load data or ALU passthrough)
- out_wa3  out  4;  out_reg_write, out_mem_to_reg  out  1 each

## Operation
- States: IDLE, RD, RD_DRAIN, WR. A 2-bit lane counter runs 0..2.
- in_valid is sampled only in IDLE. Upstream holds its inputs stable while stall=1.
- In IDLE with in_valid:
  - mem_write=1: capture all inputs and go to WR, lane=0. mem_write takes priority if mem_to_reg is also set.
  - else mem_to_reg=1: capture and go to RD, lane=0.
  - else (passthrough): register out_data=addr_vec and control/wa3, and assert out_valid next cycle. State stays IDLE and stall is not asserted.
- WR: mem_we=1, mem_addr=cap_addr[lane], mem_wdata=cap_wdata[lane]. Lane increments each cycle. After lane 2, register out_valid=1 (out_data=cap_addr) and return to IDLE.
- RD: mem_re=1, mem_addr=cap_addr[lane].
  - mem_rdata arriving each cycle after the first is stored into lane-1.
  - After lane 2, go to RD_DRAIN.
- RD_DRAIN: store mem_rdata into lane 2. Register out_data and out_valid=1, then go to IDLE.
- stall = (state != IDLE), combinational.
- mem_addr/mem_wdata are 0 and mem_we/mem_re are 0 in IDLE and RD_DRAIN. These outputs are combinational from state and captured registers.
- No arithmetic. Widths pass through unchanged.

## Timing
- Reset values: state IDLE, lane 0; stall 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, out_valid 0, out_data all 0, out_wa3 0, out_reg_write 0, out_mem_to_reg 0.
- Timeline below is relative to T, the accept cycle (IDLE, in_valid=1).

| Instruction type | Memory strobes | stall high | out_valid pulse | Next accept |
|---|---|---|---|---|
| Passthrough | none | never | T+1 | T+1 (back-to-back, one per cycle) |
| Load | mem_re T+1..T+3; rdata T+2..T+4 | T+1..T+4 | T+5 | T+5 |
| Store | mem_we T+1..T+3 | T+1..T+3 | T+4 | T+4 |

- out_valid is high for exactly one cycle. out_data holds its value until the next out_valid.
- Reset mid-operation:
  - State returns to IDLE at the reset edge, so strobes and stall drop in the following cycle.
  - Partial read data is discarded, and no out_valid is produced for the aborted instruction.
- A new in_valid is ignored during RD/WR/RD_DRAIN. It is never double-accepted.

## Structure
- Shared package gpu_mem_pkg: LANES constant, the state enum (IDLE, RD, RD_DRAIN, WR), and the lane_vec_t typedef ([LANES-1:0][N-1:0]).
- Single flat module. The lane select is an inline mux, so no sub-module is needed.

## Test plan
- Passthrough: three back-to-back instructions with addr_vec={1,2,3}, {4,5,6}, {7,8,9}, mem ops 0 -> out_valid on three consecutive cycles with the matching out_data; stall stays 0.
- Load: addr_vec={0x10,0x20,0x30}, wa3=5, memory model returns addr+1 -> mem_re T+1..T+3 with those addresses; out_valid at T+5 with out_data={0x11,0x21,0x31}, out_wa3=5; stall high T+1..T+4.
- Store: addr_vec={4,8,12}, wdata_vec={0x3FFFF,0,7} -> mem_we T+1..T+3 with the address/data pairs in lane order; out_valid at T+4.
- Load immediately followed by a held passthrough instruction -> the second is accepted only at T+5; its out_valid comes at T+6.
- Both mem_to_reg=1 and mem_write=1 -> store sequence only; no mem_re is ever asserted.
- Reset asserted at T+2 of a load -> the cycle after the reset edge has stall=0, mem_re=0, out_valid=0, out_data=0; a subsequent passthrough behaves normally.
